uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART_TRANSMITTER between NUM_REQUESTERS byte-stream clients.
- Arbitrates round-robin at message boundaries.
- Forwards the granted client's bytes to the transmitter's data_i / data_write_i, throttled by data_buffer_full_o.
- Sits between the client logic and UART_TRANSMITTER. Buffer threshold and baudrate are wired directly to the transmitter and are outside this block.

Parameters:
- NUM_REQUESTERS, 4, number of clients (2..8)
- DATA_WIDTH, 8, byte width; must match the transmitter data_i
- MAX_BURST, 16, max bytes per grant before forced release; 0 = unlimited (release only on last)

Ports:
- clock_i  in  1  system clock
- reset_n_i  in  1  synchronous active-low reset
- req_valid_i  in  NUM_REQUESTERS  client i has a byte
- req_data_i  in  NUM_REQUESTERS*DATA_WIDTH  client i byte at slice [i*DATA_WIDTH +: DATA_WIDTH]
- req_last_i  in  NUM_REQUESTERS  byte is the final byte of the client's message
- req_ready_o  out  NUM_REQUESTERS  byte accepted this cycle when valid&ready
- grant_o  out  NUM_REQUESTERS  one-hot current owner, all-zero when idle
- tx_data_o  out  DATA_WIDTH  to transmitter data_i
- tx_write_o  out  1  to transmitter data_write_i, single-cycle pulse
- tx_buffer_full_i  in  1  from transmitter data_buffer_full_o
- busy_o  out  1  high while a grant is held

Behaviour:
- Clock and reset: one clock, clock_i. Reset is synchronous and active-low (reset_n_i sampled on the rising edge).
- Reset values: state IDLE, grant_o=0, tx_write_o=0, tx_data_o=0, busy_o=0, rr_ptr=0, burst_cnt=0.
- Reset mid-message: the grant is dropped and any pending write is suppressed. Bytes already in the transmitter buffer are not recalled.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If any req_valid_i is set, pick the first set index searching upward from rr_ptr with wrap (rr_ptr itself has highest priority).
  - Next edge: grant_o = onehot(pick), busy_o=1, burst_cnt=0, state GRANT.
  - req_ready_o=0 in IDLE. A grant is never issued in the same cycle it is requested.
- GRANT, owner g:
  - req_ready_o[g] = req_valid_i[g] & ~tx_buffer_full_i & ~tx_write_o (combinational). All other ready bits are 0.
  - The ~tx_write_o term enforces at most one accept every 2 cycles, giving data_buffer_full_o one cycle to reflect the previous write. This is ample for UART rates.
- Accept (valid&ready):
  - Next edge: tx_data_o = req byte, tx_write_o=1 (exactly one cycle), burst_cnt+1.
  - Latency from accept to tx_write_o is 1 cycle.
  - tx_data_o holds its last value when tx_write_o=0.
- Release: on an accept with req_last_i[g]=1, or with MAX_BURST!=0 and burst_cnt==MAX_BURST-1:
  - Next edge: state IDLE, grant_o=0, busy_o=0, rr_ptr=(g+1) mod NUM_REQUESTERS.
  - The IDLE cycle that follows gives a minimum 1-cycle gap between owners.
- Owner stalls (valid low, not last): the grant is held indefinitely, so messages are never interleaved unless MAX_BURST forces a release.
- tx_buffer_full_i high: no accepts. The grant is held and burst_cnt is frozen.
- Simultaneous requests: strictly resolved by rr_ptr. A non-owner's valid is ignored until the next IDLE.
- Wrap-around: rr_ptr wraps from NUM_REQUESTERS-1 to 0. burst_cnt is wide enough for MAX_BURST, clog2(MAX_BURST+1) bits, min 1.
- Invariants: grant_o is one-hot or zero; req_ready_o is a subset of grant_o; tx_write_o never high on two consecutive cycles.

Decomposition:
- Package uart_tx_arbiter_pkg: state enum {IDLE, GRANT}, DATA_WIDTH_DEFAULT=8, and a helper function clog2-based counter width.
- Sub-module rr_priority_picker: combinational. Inputs are the request vector and rr_ptr; outputs are the one-hot pick and a valid flag. It is reusable by other arbiters.

Test Plan:
- Reset, then client 1 sends 0x41,0x42,0x43(last) with tx_buffer_full_i=0 -> tx_write_o pulses on alternate cycles with data 0x41,0x42,0x43; grant_o=0010 throughout; IDLE afterwards with rr_ptr=2.
- All 4 clients request a 2-byte message simultaneously from reset -> grants in order 0,1,2,3; bytes never interleaved; one idle cycle between grants.
- Client 0 mid-message, tx_buffer_full_i held high for 10 cycles -> req_ready_o=0 and no tx_write_o for those 10 cycles; transfer resumes when full drops; no byte lost or duplicated.
- MAX_BURST=4, client 2 streams 6 bytes with last on byte 6, client 3 waiting -> client 2 released after 4 bytes, client 3 served, then client 2 regains the grant for bytes 5-6.
- reset_n_i=0 for one cycle during client 1's second byte -> next cycle grant_o=0, tx_write_o=0, busy_o=0; a later request from client 1 is granted first (rr_ptr=0 search reaches 1 when client 0 is idle).
- Owner drops valid for 5 cycles mid-message while client 0 requests -> grant held by the owner, client 0 is not granted until the owner's last byte.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared state encoding and sizing helpers for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DATA_WIDTH_DEFAULT = 8;

  // Counter width able to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: one-hot first request at or above i_ptr, with wrap.
// Purely combinational, no backpressure; o_valid flags that any request is present.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_pick,
  output logic          o_valid
);

  logic [2*N-1:0] w_rot_full;
  logic [N-1:0]   w_rot;
  logic [PW-1:0]  w_off;
  logic [PW:0]    w_sum;
  logic [PW-1:0]  w_idx;

  // Rotating the doubled vector puts i_ptr at bit 0, so the lowest set bit wins.
  assign w_rot_full = {i_req, i_req} >> i_ptr;
  assign w_rot      = w_rot_full[N-1:0];

  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = PW'(k);
    end
  end

  assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
  assign w_idx   = (w_sum >= (PW + 1)'(N)) ? PW'(w_sum - (PW + 1)'(N)) : w_sum[PW-1:0];
  assign o_valid = |i_req;
  assign o_pick  = o_valid ? (N'(1) << w_idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among byte-stream clients, round-robin at message boundaries.
// One cycle accept->write; accepts stall while the transmitter buffer is full or a write is in flight.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int MAX_BURST      = 16
) (
  input  logic                                 clock_i,
  input  logic                                 reset_n_i,
  input  logic [NUM_REQUESTERS-1:0]            req_valid_i,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQUESTERS-1:0]            req_last_i,
  output logic [NUM_REQUESTERS-1:0]            req_ready_o,
  output logic [NUM_REQUESTERS-1:0]            grant_o,
  output logic [DATA_WIDTH-1:0]                tx_data_o,
  output logic                                 tx_write_o,
  input  logic                                 tx_buffer_full_i,
  output logic                                 busy_o
);

  localparam int PW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int CW = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] BURST_LAST = (MAX_BURST == 0) ? '0 : CW'(MAX_BURST - 1);

  state_t                    r_state;
  logic [NUM_REQUESTERS-1:0] r_grant;
  logic [PW-1:0]             r_owner;
  logic [PW-1:0]             r_rr_ptr;
  logic [CW-1:0]             r_burst_cnt;
  logic [DATA_WIDTH-1:0]     r_tx_data;
  logic                      r_tx_write;
  logic                      r_busy;

  logic [NUM_REQUESTERS-1:0] w_pick;
  logic                      w_pick_vld;
  logic [PW-1:0]             w_pick_idx;
  logic                      w_accept;
  logic                      w_release;
  logic [PW-1:0]             w_next_ptr;
  logic [DATA_WIDTH-1:0]     w_owner_data;

  rr_priority_picker #(
    .N  (NUM_REQUESTERS),
    .PW (PW)
  ) u_picker (
    .i_req   (req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_pick  (w_pick),
    .o_valid (w_pick_vld)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (w_pick[i]) w_pick_idx = PW'(i);
    end
  end

  // Blocking on r_tx_write gives the buffer-full flag a cycle to catch up with the last write.
  assign w_accept     = (r_state == GRANT) && req_valid_i[r_owner] && !tx_buffer_full_i && !r_tx_write;
  assign w_release    = req_last_i[r_owner] || ((MAX_BURST != 0) && (r_burst_cnt == BURST_LAST));
  assign w_next_ptr   = (r_owner == PW'(NUM_REQUESTERS - 1)) ? '0 : r_owner + 1'b1;
  assign w_owner_data = req_data_i[r_owner*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_tx_data   <= '0;
      r_tx_write  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_tx_write <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_state     <= GRANT;
            r_grant     <= w_pick;
            r_owner     <= w_pick_idx;
            r_burst_cnt <= '0;
            r_busy      <= 1'b1;
          end
        end
        GRANT: begin
          if (w_accept) begin
            r_tx_data   <= w_owner_data;
            r_tx_write  <= 1'b1;
            r_burst_cnt <= r_burst_cnt + 1'b1;
            if (w_release) begin
              r_state  <= IDLE;
              r_grant  <= '0;
              r_busy   <= 1'b0;
              r_rr_ptr <= w_next_ptr;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o = w_accept ? r_grant : '0;
  assign grant_o     = r_grant;
  assign tx_data_o   = r_tx_data;
  assign tx_write_o  = r_tx_write;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 clients, MAX_BURST=4) with byte-stream client drivers.
module tb_uart_tx_arbiter;

  logic        clock_i;
  logic        reset_n_i;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_last_i;
  logic [3:0]  req_ready_o;
  logic [3:0]  grant_o;
  logic [7:0]  tx_data_o;
  logic        tx_write_o;
  logic        tx_buffer_full_i;
  logic        busy_o;

  uart_tx_arbiter #(
    .NUM_REQUESTERS (4),
    .DATA_WIDTH     (8),
    .MAX_BURST      (4)
  ) dut (
    .clock_i          (clock_i),
    .reset_n_i        (reset_n_i),
    .req_valid_i      (req_valid_i),
    .req_data_i       (req_data_i),
    .req_last_i       (req_last_i),
    .req_ready_o      (req_ready_o),
    .grant_o          (grant_o),
    .tx_data_o        (tx_data_o),
    .tx_write_o       (tx_write_o),
    .tx_buffer_full_i (tx_buffer_full_i),
    .busy_o           (busy_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int inv_err = 0;

  logic [7:0] src_dat [4][16];
  logic       src_lst [4][16];
  int         src_len [4];
  int         src_idx [4];
  logic [3:0] stall;
  logic [3:0] drv_acc;

  logic [7:0] wr_q[$];
  int         wr_cyc[$];
  logic [3:0] gn_q[$];
  logic [3:0] prev_gnt = 4'h0;
  logic       prev_wr = 1'b0;

  always @(posedge clock_i) cyc <= cyc + 1;

  // Record every transmitter write, every grant change, and structural invariants.
  always @(negedge clock_i) begin
    if (tx_write_o === 1'b1) begin
      wr_q.push_back(tx_data_o);
      wr_cyc.push_back(cyc);
    end
    if (grant_o !== prev_gnt) begin
      gn_q.push_back(grant_o);
      prev_gnt = grant_o;
    end
    if (cyc > 2) begin
      if (!$onehot0(grant_o) || ((req_ready_o & ~grant_o) != 4'h0) || (tx_write_o && prev_wr))
        inv_err++;
    end
    prev_wr = tx_write_o;
  end

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      if (src_idx[i] < src_len[i] && !stall[i]) begin
        req_valid_i[i]        = 1'b1;
        req_data_i[i*8 +: 8]  = src_dat[i][src_idx[i]];
        req_last_i[i]         = src_lst[i][src_idx[i]];
      end else begin
        req_valid_i[i]        = 1'b0;
        req_data_i[i*8 +: 8]  = 8'h00;
        req_last_i[i]         = 1'b0;
      end
    end
  endtask

  // Clients advance one byte per handshake seen mid-cycle.
  initial begin
    forever begin
      @(negedge clock_i);
      drv_acc = req_valid_i & req_ready_o;
      @(posedge clock_i);
      #1;
      for (int i = 0; i < 4; i++) if (drv_acc[i]) src_idx[i]++;
      refresh();
    end
  end

  task automatic step();
    @(posedge clock_i);
    #2;
  endtask

  task automatic load_msg(input int c, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      src_dat[c][k] = base + 8'(k);
      src_lst[c][k] = (k == n - 1);
    end
    src_idx[c] = 0;
    src_len[c] = n;
    refresh();
  endtask

  task automatic clear_mon();
    wr_q.delete();
    wr_cyc.delete();
    gn_q.delete();
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    tx_buffer_full_i = 1'b0;
    stall = 4'h0;
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0;
      src_idx[i] = 0;
    end
    refresh();
    step();
    step();
    reset_n_i = 1'b1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      step();
      n++;
      done = (busy_o === 1'b0) && (tx_write_o === 1'b0);
      for (int i = 0; i < 4; i++) if (src_idx[i] < src_len[i]) done = 0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: not idle after %0d cycles (busy=%b)", name, budget, busy_o);
    end
  endtask

  task automatic wait_write(input string name);
    int n;
    n = 0;
    while (tx_write_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (tx_write_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_first_write: no tx_write_o within 40 cycles", name);
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    tx_buffer_full_i = 1'b0;
    stall = 4'h0;
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0;
      src_idx[i] = 0;
    end
    refresh();
    step();
    checks++; if (grant_o !== 4'h0) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant_o); end
    checks++; if (tx_write_o !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", tx_write_o); end
    checks++; if (tx_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", tx_data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (req_ready_o !== 4'h0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready_o); end
    step();
    reset_n_i = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] exp_w [3] = '{8'h41, 8'h42, 8'h43};
    logic [3:0] exp_g [2] = '{4'b0010, 4'b0000};
    logic [7:0] exp_w2 [2] = '{8'h52, 8'h51};
    logic [3:0] exp_g2 [4] = '{4'b0100, 4'b0000, 4'b0010, 4'b0000};
    clear_mon();
    load_msg(1, 3, 8'h41);
    wait_done(60, "single");
    checks++; if (wr_q.size() != 3) begin errors++; $display("FAIL single_count: got %0d writes want 3", wr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wr_q.size() || wr_q[i] !== exp_w[i]) begin
        errors++; $display("FAIL single_data[%0d]: got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : 8'hxx, exp_w[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (i >= wr_cyc.size() || wr_cyc[i] - wr_cyc[i-1] != 2) begin
        errors++; $display("FAIL single_spacing[%0d]: got gap %0d want 2", i, (i < wr_cyc.size()) ? wr_cyc[i] - wr_cyc[i-1] : -1);
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (gn_q.size() != 2 || gn_q[i] !== exp_g[i]) begin
        errors++; $display("FAIL single_grant[%0d]: got %b (%0d changes) want %b", i, (i < gn_q.size()) ? gn_q[i] : 4'hx, gn_q.size(), exp_g[i]);
      end
    end
    // Pointer now sits at client 2, so 2 must beat 1.
    clear_mon();
    load_msg(1, 1, 8'h51);
    load_msg(2, 1, 8'h52);
    wait_done(60, "rrptr");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gn_q.size() != 4 || gn_q[i] !== exp_g2[i]) begin
        errors++; $display("FAIL rrptr_grant[%0d]: got %b want %b", i, (i < gn_q.size()) ? gn_q[i] : 4'hx, exp_g2[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wr_q.size() != 2 || wr_q[i] !== exp_w2[i]) begin
        errors++; $display("FAIL rrptr_data[%0d]: got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : 8'hxx, exp_w2[i]);
      end
    end
  endtask

  task automatic test_all_four();
    logic [7:0] exp_w [8] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41};
    logic [3:0] exp_g [8] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
    do_reset();
    clear_mon();
    for (int c = 0; c < 4; c++) load_msg(c, 2, 8'((c + 1) * 16));
    wait_done(120, "all4");
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_q.size() != 8 || wr_q[i] !== exp_w[i]) begin
        errors++; $display("FAIL all4_data[%0d]: got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : 8'hxx, exp_w[i]);
      end
      checks++;
      if (gn_q.size() != 8 || gn_q[i] !== exp_g[i]) begin
        errors++; $display("FAIL all4_grant[%0d]: got %b want %b", i, (i < gn_q.size()) ? gn_q[i] : 4'hx, exp_g[i]);
      end
    end
  endtask

  task automatic test_buffer_full();
    logic [7:0] exp_w [3] = '{8'hA0, 8'hA1, 8'hA2};
    clear_mon();
    load_msg(0, 3, 8'hA0);
    wait_write("full");
    tx_buffer_full_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (req_ready_o !== 4'h0 || tx_write_o !== 1'b0 || grant_o !== 4'b0001) begin
        errors++; $display("FAIL full_hold[%0d]: ready=%b write=%b grant=%b want 0000/0/0001", i, req_ready_o, tx_write_o, grant_o);
      end
    end
    tx_buffer_full_i = 1'b0;
    wait_done(60, "full");
    checks++; if (wr_q.size() != 3) begin errors++; $display("FAIL full_count: got %0d writes want 3", wr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wr_q.size() || wr_q[i] !== exp_w[i]) begin
        errors++; $display("FAIL full_data[%0d]: got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : 8'hxx, exp_w[i]);
      end
    end
  endtask

  task automatic test_max_burst();
    logic [7:0] exp_w [8] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC0, 8'hC1, 8'hB4, 8'hB5};
    logic [3:0] exp_g [6] = '{4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0100, 4'b0000};
    do_reset();
    clear_mon();
    load_msg(2, 6, 8'hB0);
    load_msg(3, 2, 8'hC0);
    wait_done(120, "burst");
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_q.size() != 8 || wr_q[i] !== exp_w[i]) begin
        errors++; $display("FAIL burst_data[%0d]: got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : 8'hxx, exp_w[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (gn_q.size() != 6 || gn_q[i] !== exp_g[i]) begin
        errors++; $display("FAIL burst_grant[%0d]: got %b want %b", i, (i < gn_q.size()) ? gn_q[i] : 4'hx, exp_g[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_w [3] = '{8'hD0, 8'hE0, 8'hF0};
    logic [3:0] exp_g [6] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000};
    clear_mon();
    load_msg(1, 3, 8'hD0);
    wait_write("rstmid");
    step();
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL rstmid_ready: got %b want 0010", req_ready_o); end
    reset_n_i = 1'b0;
    step();
    checks++; if (grant_o !== 4'h0) begin errors++; $display("FAIL rstmid_grant: got %b want 0000", grant_o); end
    checks++; if (tx_write_o !== 1'b0) begin errors++; $display("FAIL rstmid_write: got %b want 0", tx_write_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
    src_len[1] = 0;
    src_idx[1] = 0;
    refresh();
    reset_n_i = 1'b1;
    load_msg(1, 1, 8'hE0);
    load_msg(3, 1, 8'hF0);
    wait_done(60, "rstmid");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_q.size() != 3 || wr_q[i] !== exp_w[i]) begin
        errors++; $display("FAIL rstmid_data[%0d]: got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : 8'hxx, exp_w[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (gn_q.size() != 6 || gn_q[i] !== exp_g[i]) begin
        errors++; $display("FAIL rstmid_grant_seq[%0d]: got %b want %b", i, (i < gn_q.size()) ? gn_q[i] : 4'hx, exp_g[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_w [4] = '{8'h60, 8'h61, 8'h62, 8'h70};
    logic [3:0] exp_g [4] = '{4'b1000, 4'b0000, 4'b0001, 4'b0000};
    clear_mon();
    load_msg(3, 3, 8'h60);
    wait_write("stall");
    stall[3] = 1'b1;
    load_msg(0, 1, 8'h70);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (grant_o !== 4'b1000 || req_ready_o !== 4'h0) begin
        errors++; $display("FAIL stall_hold[%0d]: grant=%b ready=%b want 1000/0000", i, grant_o, req_ready_o);
      end
    end
    stall[3] = 1'b0;
    refresh();
    wait_done(60, "stall");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_q.size() != 4 || wr_q[i] !== exp_w[i]) begin
        errors++; $display("FAIL stall_data[%0d]: got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : 8'hxx, exp_w[i]);
      end
      checks++;
      if (gn_q.size() != 4 || gn_q[i] !== exp_g[i]) begin
        errors++; $display("FAIL stall_grant[%0d]: got %b want %b", i, (i < gn_q.size()) ? gn_q[i] : 4'hx, exp_g[i]);
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (inv_err != 0) begin
      errors++; $display("FAIL invariants: got %0d violating cycles want 0", inv_err);
    end
  endtask

  initial begin
    reset_n_i = 1'b0;
    tx_buffer_full_i = 1'b0;
    req_valid_i = 4'h0;
    req_data_i = 32'h0;
    req_last_i = 4'h0;
    stall = 4'h0;
    test_reset();
    test_single();
    test_all_four();
    test_buffer_full();
    test_max_burst();
    test_reset_mid();
    test_stall();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
